sram_ctrl: RTL and testbench

Initiator-side controller for one asynchronous 32-bit SRAM bank (base or ext). It converts a single-outstanding valid/ready request bus from the core into timed SRAM pin sequences: addr, be_n, ce_n, oe_n and we_n, plus the tri-state data enable/drive/sample signals that feed the board's inout wrapper. It sits inside subtop, one instance per bank, and directly faces the sram simulation model and real board SRAM.

---
 rtl/sram_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sram_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: initiator-side controller for one asynchronous 32-bit SRAM bank.
// Turns a single-outstanding valid/ready request into timed SRAM pin
// sequences. Every output comes from a flop.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), synchronous active-low reset
//   req_valid_i/ready_o  request handshake; ready only in IDLE, out of reset
//   req_we_i             1 = write, 0 = read
//   req_addr_i           word address
//   req_wdata_i          write data
//   req_wstrb_i          byte enables, active high
//   resp_valid_o         one-cycle pulse: read data valid / write done
//   resp_rdata_o         read data (0 on write responses)
//   sram_addr_o          SRAM address pins
//   sram_be_n_o          byte enables, active low
//   sram_ce_n_o          chip enable, active low
//   sram_oe_n_o          output enable, active low
//   sram_we_n_o          write enable, active low
//   sram_data_wen_o      1 = controller drives the data bus
//   sram_wdata_o         value for the data bus when driving
//   sram_rdata_i         value sampled from the data bus
module sram_ctrl #(
  parameter int ADDR_W       = 20,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_wstrb_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_data_wen_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  localparam int MAXC  = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_n_q, be_n_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              dwen_q, dwen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rvld_q, rvld_d;
  logic [31:0]       rdata_q, rdata_d;

  // rdy_q is a registered copy of "next state is IDLE", cleared by reset,
  // so ready stays low while reset is held and rises one cycle after release.
  logic accept;
  assign accept      = req_valid_i && rdy_q;
  assign req_ready_o = rdy_q;

  // state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  // next state; cnt counts the remaining cycles of RD / WR_PULSE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = req_we_i ? WR_SETUP : RD;
        cnt_d   = RD_LAST;
      end
      RD: if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = WR_LAST;
      end
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
      WR_HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  // output next-values: pins for the state being entered are computed here,
  // so the flops present them during that state with no comb path to pins.
  always_comb begin
    addr_d  = addr_q;
    be_n_d  = be_n_q;
    ce_n_d  = ce_n_q;
    oe_n_d  = oe_n_q;
    we_n_d  = we_n_q;
    dwen_d  = dwen_q;
    wdata_d = wdata_q;
    rvld_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        be_n_d = 4'hF;
        ce_n_d = 1'b1;
        oe_n_d = 1'b1;
        we_n_d = 1'b1;
        dwen_d = 1'b0;
        if (accept) begin
          addr_d = req_addr_i;
          ce_n_d = 1'b0;
          if (req_we_i) begin
            be_n_d  = ~req_wstrb_i;
            dwen_d  = 1'b1;
            wdata_d = req_wdata_i;
          end else begin
            be_n_d = 4'h0;
            oe_n_d = 1'b0;
          end
        end
      end
      RD: if (cnt_q == '0) begin
        rdata_d = sram_rdata_i;
        rvld_d  = 1'b1;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        be_n_d  = 4'hF;
      end
      WR_SETUP: we_n_d = 1'b0;
      WR_PULSE: if (cnt_q == '0) we_n_d = 1'b1;
      WR_HOLD: begin
        ce_n_d  = 1'b1;
        dwen_d  = 1'b0;
        be_n_d  = 4'hF;
        rvld_d  = 1'b1;
        rdata_d = 32'h0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      be_n_q  <= 4'hF;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dwen_q  <= 1'b0;
      wdata_q <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      be_n_q  <= be_n_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dwen_q  <= dwen_d;
      wdata_q <= wdata_d;
      rvld_q  <= rvld_d;
      rdata_q <= rdata_d;
    end
  end

  assign sram_addr_o     = addr_q;
  assign sram_be_n_o     = be_n_q;
  assign sram_ce_n_o     = ce_n_q;
  assign sram_oe_n_o     = oe_n_q;
  assign sram_we_n_o     = we_n_q;
  assign sram_data_wen_o = dwen_q;
  assign sram_wdata_o    = wdata_q;
  assign resp_valid_o    = rvld_q;
  assign resp_rdata_o    = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl: two instances (default timing, and READ_CYCLES=1 /
// WRITE_CYCLES=4), each with a small SRAM model. Expected responses go into a
// scoreboard queue; a negedge monitor pops and compares on resp_valid and
// checks the pin-level invariants every cycle.
module tb_sram_ctrl;
  localparam int AW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            req_valid [2];
  logic            req_ready [2];
  logic            req_we    [2];
  logic [AW-1:0]   req_addr  [2];
  logic [31:0]     req_wdata [2];
  logic [3:0]      req_wstrb [2];
  logic            resp_valid[2];
  logic [31:0]     resp_rdata[2];
  logic [AW-1:0]   sram_addr [2];
  logic [3:0]      be_n      [2];
  logic            ce_n      [2];
  logic            oe_n      [2];
  logic            we_n      [2];
  logic            dwen      [2];
  logic [31:0]     swdata    [2];
  logic [31:0]     srdata    [2];

  sram_ctrl #(.ADDR_W(AW)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_wstrb_i(req_wstrb[0]),
    .resp_valid_o(resp_valid[0]), .resp_rdata_o(resp_rdata[0]),
    .sram_addr_o(sram_addr[0]), .sram_be_n_o(be_n[0]), .sram_ce_n_o(ce_n[0]),
    .sram_oe_n_o(oe_n[0]), .sram_we_n_o(we_n[0]), .sram_data_wen_o(dwen[0]),
    .sram_wdata_o(swdata[0]), .sram_rdata_i(srdata[0]));

  sram_ctrl #(.ADDR_W(AW), .READ_CYCLES(1), .WRITE_CYCLES(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_wstrb_i(req_wstrb[1]),
    .resp_valid_o(resp_valid[1]), .resp_rdata_o(resp_rdata[1]),
    .sram_addr_o(sram_addr[1]), .sram_be_n_o(be_n[1]), .sram_ce_n_o(ce_n[1]),
    .sram_oe_n_o(oe_n[1]), .sram_we_n_o(we_n[1]), .sram_data_wen_o(dwen[1]),
    .sram_wdata_o(swdata[1]), .sram_rdata_i(srdata[1]));

  function automatic int rdc(int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int wrc(int d); return (d == 0) ? 2 : 4; endfunction

  // SRAM models, 256 words each (address bits [7:0]); preloaded on the first edge
  logic [31:0] mem [2][256];
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 256; i++) mem[d][i] <= 32'h0;
      mem[0][8'h23] <= 32'hDEADBEEF;
      mem[0][8'h40] <= 32'hAABBCCDD;
      mem[0][8'h00] <= 32'h11110000;
      mem[0][8'h01] <= 32'h22220001;
      mem[0][8'h02] <= 32'h33330002;
      mem[0][8'h03] <= 32'h44440003;
      mem[0][8'h50] <= 32'h0BADF00D;
      mem[1][8'h05] <= 32'h5A5A0005;
    end else begin
      for (int d = 0; d < 2; d++)
        if (!ce_n[d] && !we_n[d])
          for (int b = 0; b < 4; b++)
            if (!be_n[d][b]) mem[d][sram_addr[d][7:0]][8*b +: 8] <= swdata[d][8*b +: 8];
    end
  end
  assign srdata[0] = (!ce_n[0] && !oe_n[0]) ? mem[0][sram_addr[0][7:0]] : 32'h0;
  assign srdata[1] = (!ce_n[1] && !oe_n[1]) ? mem[1][sram_addr[1][7:0]] : 32'h0;

  typedef struct { int d; logic [31:0] data; int due; } exp_t;
  exp_t sbq[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, req);
    end
  endtask

  // monitor / invariant checker
  logic          rst_prev = 1'b0;
  always @(posedge clk) rst_prev <= rst_n;

  int            oe_run [2] = '{0, 0};
  int            we_run [2] = '{0, 0};
  logic          dwen_prev [2] = '{1'b0, 1'b0};
  logic          we_prev   [2] = '{1'b1, 1'b1};
  logic [AW-1:0] addr_prev [2];
  logic [3:0]    be_prev   [2];
  logic [31:0]   wd_prev   [2];
  logic [3:0]    exp_be    [2] = '{4'hF, 4'hF};
  logic          rd_only = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (resp_valid[d]) begin
        if (sbq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_resp dut%0d @cyc %0d: got data %h, expected no response", d, cyc, resp_rdata[d]);
        end else begin
          e = sbq.pop_front();
          chk("resp_dut", 32'(d), 32'(e.d));
          chk("resp_data", resp_rdata[d], e.data);
          chk("resp_cycle", 32'(cyc), 32'(e.due));
        end
      end
      chk("inv_wen_and_oe", 32'(dwen[d] && !oe_n[d]), 32'd0);
      if (!we_n[d]) begin
        chk("inv_we_ctx", 32'({ce_n[d], dwen[d]}), 32'b01);
        chk("pulse_be_n", 32'(be_n[d]), 32'(exp_be[d]));
        if (!we_prev[d]) begin
          chk("stable_addr", 32'(sram_addr[d]), 32'(addr_prev[d]));
          chk("stable_be_n", 32'(be_n[d]), 32'(be_prev[d]));
          chk("stable_wdata", swdata[d], wd_prev[d]);
        end
      end
      if (rst_prev) chk("inv_ce_vs_idle", 32'(ce_n[d]), 32'(req_ready[d]));
      if (rd_only)  chk("rd_no_drive", 32'(dwen[d]), 32'd0);
      // low-pulse lengths; a pulse cut short by reset is not measured
      if (!oe_n[d]) oe_run[d]++;
      else begin
        if (oe_run[d] != 0 && rst_prev) chk("oe_low_cycles", 32'(oe_run[d]), 32'(rdc(d)));
        oe_run[d] = 0;
      end
      if (!we_n[d]) begin
        if (we_run[d] == 0) chk("we_setup", 32'({dwen_prev[d], we_prev[d]}), 32'b11);
        we_run[d]++;
      end else begin
        if (we_run[d] != 0 && rst_prev) begin
          chk("we_low_cycles", 32'(we_run[d]), 32'(wrc(d)));
          chk("we_hold", 32'(dwen[d]), 32'd1);
        end
        we_run[d] = 0;
      end
      dwen_prev[d] = dwen[d];
      we_prev[d]   = we_n[d];
      addr_prev[d] = sram_addr[d];
      be_prev[d]   = be_n[d];
      wd_prev[d]   = swdata[d];
    end
  end

  // called at posedge+1; returns at posedge+1 just after the acceptance edge
  // with req_valid still high (caller drops it or issues the next request)
  task automatic issue(input int d, input bit we, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] exp_data, input bit push);
    int lim;
    exp_t e;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a;
    req_wdata[d] = wd;   req_wstrb[d] = st;
    if (we) exp_be[d] = ~st;
    lim = 0;
    while (!req_ready[d] && lim < 40) begin @(posedge clk); #1; lim++; end
    if (!req_ready[d]) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout dut%0d: req_ready stayed 0, expected 1", d);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (push) begin
      e.d = d; e.data = exp_data;
      e.due = cyc + (we ? wrc(d) + 2 : rdc(d));
      sbq.push_back(e);
    end
  endtask

  task automatic drop(input int d); req_valid[d] = 1'b0; endtask

  task automatic wait_done();
    int lim = 0;
    while (sbq.size() != 0 && lim < 60) begin @(posedge clk); #1; lim++; end
    if (sbq.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL resp_timeout: %0d responses outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0;   req_wstrb[d] = '0;
    end
    // reset held with requests pending
    repeat (3) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_ready", 32'(req_ready[d]), 32'd0);
        chk("rst_pins", 32'({ce_n[d], oe_n[d], we_n[d], be_n[d], dwen[d]}), 32'b111_1111_0);
        chk("rst_resp", 32'(resp_valid[d]), 32'd0);
      end
    end
    rst_n = 1'b1; drop(0); drop(1);
    @(posedge clk); #1;
    chk("rel_ready0", 32'(req_ready[0]), 32'd1);
    chk("rel_ready1", 32'(req_ready[1]), 32'd1);

    // single read
    issue(0, 1'b0, 20'h00123, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1); drop(0);
    wait_done();

    // byte write, then read back: bytes 0 and 2 replaced
    issue(0, 1'b1, 20'h00040, 32'h11223344, 4'b0101, 32'h0, 1'b1); drop(0);
    wait_done();
    issue(0, 1'b0, 20'h00040, 32'h0, 4'h0, 32'hAA22CC44, 1'b1); drop(0);
    wait_done();

    // back-to-back reads with req_valid held high
    rd_only = 1'b1;
    issue(0, 1'b0, 20'h0, 32'h0, 4'h0, 32'h11110000, 1'b1);
    issue(0, 1'b0, 20'h1, 32'h0, 4'h0, 32'h22220001, 1'b1);
    issue(0, 1'b0, 20'h2, 32'h0, 4'h0, 32'h33330002, 1'b1);
    issue(0, 1'b0, 20'h3, 32'h0, 4'h0, 32'h44440003, 1'b1);
    drop(0);
    wait_done();
    rd_only = 1'b0;

    // wstrb=0: full sequence, no bytes change
    issue(0, 1'b1, 20'h00050, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b1); drop(0);
    wait_done();
    issue(0, 1'b0, 20'h00050, 32'h0, 4'h0, 32'h0BADF00D, 1'b1); drop(0);
    wait_done();

    // reset in WR_PULSE: write aborted, no response
    issue(0, 1'b1, 20'h00060, 32'h12345678, 4'hF, 32'h0, 1'b0); drop(0);
    @(posedge clk); #1;
    chk("mid_we_low", 32'(we_n[0]), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_pins", 32'({we_n[0], dwen[0], ce_n[0], oe_n[0]}), 32'b1011);
    chk("abort_ready", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    issue(0, 1'b1, 20'h00010, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b1); drop(0);
    wait_done();
    issue(0, 1'b0, 20'h00010, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b1); drop(0);
    wait_done();

    // READ_CYCLES=1, WRITE_CYCLES=4 instance
    issue(1, 1'b0, 20'h00005, 32'h0, 4'h0, 32'h5A5A0005, 1'b1); drop(1);
    wait_done();
    issue(1, 1'b1, 20'h00006, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1); drop(1);
    wait_done();
    issue(1, 1'b0, 20'h00006, 32'h0, 4'h0, 32'hCAFEF00D, 1'b1); drop(1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
